// File: rtl/serial_subtractor_4bit.sv
// Bit-serial 4-bit subtractor: computes A - B - B0 one bit per clock, LSB first,
// and reports the result on Diff/Borrow with a one-cycle Done pulse.
module serial_subtractor_4bit (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       B0,
  output logic [3:0] Diff,
  output logic       Borrow,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] a_sh;
  logic [3:0] b_sh;
  logic [3:0] work;
  logic       br;
  logic [1:0] cnt;
  logic       d;
  logic       br_next;
  logic       last_bit;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  assign d        = a_sh[0] ^ b_sh[0] ^ br;
  assign br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign last_bit = (cnt == 2'd3);

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_next = RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Diff/Borrow are only written on the final RUN edge, so they hold the
  // previous result through IDLE and while the next operation is running.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_sh   <= 4'd0;
      b_sh   <= 4'd0;
      work   <= 4'd0;
      br     <= 1'b0;
      cnt    <= 2'd0;
      Diff   <= 4'd0;
      Borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_sh <= A;
            b_sh <= B;
            br   <= B0;
            cnt  <= 2'd0;
          end
        end
        RUN: begin
          work <= {d, work[3:1]};
          a_sh <= {1'b0, a_sh[3:1]};
          b_sh <= {1'b0, b_sh[3:1]};
          br   <= br_next;
          cnt  <= cnt + 2'd1;
          if (last_bit) begin
            Diff   <= {d, work[3:1]};
            Borrow <= br_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit: directed vector table, random
// operands against an arithmetic model, reset abort and back-to-back Start.
module tb_serial_subtractor_4bit;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic [3:0] A;
  logic [3:0] B;
  logic       B0;
  logic [3:0] Diff;
  logic       Borrow;
  logic       Busy;
  logic       Done;

  int compares = 0;
  int failures = 0;

  logic [3:0] expDiff   = 4'd0;
  logic       expBorrow = 1'b0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       b0;
    logic [3:0] diff;
    logic       borrow;
  } vector_t;

  vector_t vectors [8];

  serial_subtractor_4bit dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .A      (A),
    .B      (B),
    .B0     (B0),
    .Diff   (Diff),
    .Borrow (Borrow),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    compares++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Reference model: plain integer subtraction, borrow when A < B + B0.
  task automatic modelSub(input logic [3:0] a, input logic [3:0] b, input logic b0,
                          output logic [3:0] diff, output logic borrow);
    int r;
    r      = int'(a) - int'(b) - int'(b0);
    diff   = 4'(r + 16);
    borrow = (r < 0);
  endtask

  // One full operation starting from IDLE, just after a rising edge.
  // With disturb set, Start stays high and operands are scrambled during RUN/DONE.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic b0,
                               input logic [3:0] wantDiff, input logic wantBorrow,
                               input bit disturb);
    Start = 1'b1; A = a; B = b; B0 = b0;
    step();
    Start = disturb;
    if (disturb) begin
      A  = 4'($urandom);
      B  = 4'($urandom);
      B0 = 1'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput("busy_run", 8'(Busy), 8'd1);
      checkOutput("done_run", 8'(Done), 8'd0);
      checkOutput("diff_hold", {3'd0, Borrow, Diff}, {3'd0, expBorrow, expDiff});
      if (disturb) A = 4'($urandom);
      step();
    end
    checkOutput("done_pulse", 8'(Done), 8'd1);
    checkOutput("busy_done", 8'(Busy), 8'd0);
    checkOutput("diff", 8'(Diff), 8'(wantDiff));
    checkOutput("borrow", 8'(Borrow), 8'(wantBorrow));
    expDiff   = wantDiff;
    expBorrow = wantBorrow;
    step();
    Start = 1'b0;
    checkOutput("done_after", 8'(Done), 8'd0);
    checkOutput("busy_after", 8'(Busy), 8'd0);
  endtask

  initial begin
    logic [3:0] md;
    logic       mb;
    int         doneSeen;

    vectors[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vectors[1] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0};
    vectors[2] = '{4'b1000, 4'b0001, 1'b1, 4'b0110, 1'b0};
    vectors[3] = '{4'b1000, 4'b1111, 1'b0, 4'b1001, 1'b1};
    vectors[4] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
    vectors[5] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    vectors[6] = '{4'b1111, 4'b0000, 1'b1, 4'b1110, 1'b0};
    vectors[7] = '{4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0};

    Reset = 1'b1; Start = 1'b0; A = 4'd0; B = 4'd0; B0 = 1'b0;
    #12;
    checkOutput("reset_outputs", {Busy, Done, Borrow, 1'b0, Diff}, 8'd0);
    Reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++)
      applyStimulus(vectors[i].a, vectors[i].b, vectors[i].b0,
                    vectors[i].diff, vectors[i].borrow, 1'b0);

    // Operands and Start changed during RUN must not affect the result.
    applyStimulus(4'b1010, 4'b0011, 1'b0, 4'b0111, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [3:0] ra, rb;
      logic       rc;
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom);
      modelSub(ra, rb, rc, md, mb);
      applyStimulus(ra, rb, rc, md, mb, (i % 4) == 3);
    end

    // Asynchronous reset on the 2nd RUN cycle aborts the operation.
    Start = 1'b1; A = 4'b1000; B = 4'b0001; B0 = 1'b0;
    step();
    Start = 1'b0;
    step();
    #2 Reset = 1'b1;
    #1;
    checkOutput("abort_outputs", {Busy, Done, Borrow, 1'b0, Diff}, 8'd0);
    Start = 1'b1;
    step();
    checkOutput("start_in_reset", 8'(Busy), 8'd0);
    #2 Reset = 1'b0;
    Start = 1'b0;
    expDiff = 4'd0; expBorrow = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (Done) doneSeen++;
    end
    checkOutput("no_done_after_abort", 8'(doneSeen), 8'd0);
    checkOutput("diff_after_abort", {3'd0, Borrow, Diff}, 8'd0);

    // Start held high: a new operation every 6 cycles.
    Start = 1'b1; A = 4'b1000; B = 4'b0001; B0 = 1'b0;
    for (int c = 0; c < 24; c++) begin
      step();
      checkOutput("held_done", 8'(Done), 8'((c % 6) == 4));
      checkOutput("held_busy", 8'(Busy), 8'((c % 6) < 4));
      if ((c % 6) == 4) checkOutput("held_diff", {3'd0, Borrow, Diff}, 8'h07);
    end
    Start = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", compares, failures);
    $finish;
  end

endmodule
